// File: rtl/divide_by_subtraction.sv
// divide_by_subtraction
//   Unsigned integer divider using repeated subtraction. A rising edge on
//   start, seen while idle or holding a result, latches the operands. The
//   block then subtracts the divisor once per clock until the remainder is
//   smaller than the divisor. For a quotient Q, done rises Q+1 edges after
//   the accept edge.
//
// Ports
//   clk          : single clock, rising-edge active
//   rst_n        : asynchronous active-low reset
//   start        : operation request; only its rising edge is used
//   dividend     : unsigned dividend, sampled at accept
//   divisor      : unsigned divisor, sampled at accept
//   outputcount  : quotient (number of subtractions performed)
//   remainder    : remainder
//   done         : result valid; held until the next accept
//
// Optional feature
//   DBS_ZERO_DIVISOR_GUARD_EN : when defined, a zero divisor completes at the
//   first busy edge with outputcount = all ones and remainder = dividend.
//   Without it, a zero divisor keeps the block busy until reset.

module divide_by_subtraction #(
   parameter int unsigned WIDTH = 512
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] outputcount,
   output logic [WIDTH-1:0] remainder,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t           state_q,   state_d;
   logic             start_q;
   logic [WIDTH-1:0] count_q,   count_d;
   logic [WIDTH-1:0] rem_q,     rem_d;
   logic [WIDTH-1:0] dvs_q,     dvs_d;
   logic             done_q,    done_d;
   logic             start_edge;
   logic             zero_guard;

   assign start_edge = start & ~start_q;

`ifdef DBS_ZERO_DIVISOR_GUARD_EN
   assign zero_guard = (dvs_q == '0);
`else
   assign zero_guard = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      done_d  = done_q;

      case (state_q)
         IDLE, DONE: begin
            if (start_edge) begin
               rem_d   = dividend;
               count_d = '0;
               dvs_d   = divisor;
               done_d  = 1'b0;
               state_d = BUSY;
            end
         end

         BUSY: begin
            // Start edges are deliberately not looked at here.
            if (zero_guard) begin
               count_d = '1;
               done_d  = 1'b1;
               state_d = DONE;
            end else if (rem_q >= dvs_q) begin
               rem_d   = rem_q - dvs_q;
               count_d = count_q + 1'b1;
            end else begin
               done_d  = 1'b1;
               state_d = DONE;
            end
         end

         default: begin
            state_d = IDLE;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         count_q <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start;
         count_q <= count_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         done_q  <= done_d;
      end
   end

   assign outputcount = count_q;
   assign remainder   = rem_q;
   assign done        = done_q;

endmodule

// File: tb/tb_divide_by_subtraction.sv
module tb_divide_by_subtraction;

   localparam int unsigned W      = 32;
   localparam int unsigned BUDGET = 2000;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic [W-1:0] outputcount;
   logic [W-1:0] remainder;
   logic         done;

   int unsigned n_cmp = 0;
   int unsigned n_mis = 0;

   typedef struct {
      logic [W-1:0] dvd;
      logic [W-1:0] dvs;
      logic [W-1:0] q;
      logic [W-1:0] r;
      int unsigned  lat;
   } vec_t;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      int unsigned  lat;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[8];

   divide_by_subtraction #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .outputcount (outputcount),
      .remainder   (remainder),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [W-1:0] q, input logic [W-1:0] r, input int unsigned lat);
      exp_t e;
      e.q   = q;
      e.r   = r;
      e.lat = lat;
      sb.push_back(e);
   endtask

   // Counts edges from the accept edge until done is seen high.
   task automatic wait_done(input int unsigned already, output int unsigned lat, output bit ok);
      ok  = 1'b0;
      lat = already;
      for (int unsigned n = already + 1; n <= BUDGET; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = n;
            ok  = 1'b1;
            break;
         end
      end
   endtask

   task automatic compare_result(input string name, input int unsigned lat, input bit ok);
      exp_t e;
      check({name, "_timeout"}, {63'd0, ok}, 64'd1);
      if (sb.size() == 0) begin
         check({name, "_sb_empty"}, 64'd0, 64'd1);
      end else begin
         e = sb.pop_front();
         check({name, "_quot"}, 64'(outputcount), 64'(e.q));
         check({name, "_rem"},  64'(remainder),   64'(e.r));
         if (ok) check({name, "_lat"}, 64'(lat), 64'(e.lat));
         // Result must stay put while waiting in DONE.
         repeat (3) @(posedge clk);
         #1;
         check({name, "_hold_q"}, 64'(outputcount), 64'(e.q));
         check({name, "_hold_r"}, 64'(remainder),   64'(e.r));
         check({name, "_hold_done"}, {63'd0, done}, 64'd1);
      end
   endtask

   task automatic run_op(input string name, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                         input logic [W-1:0] q, input logic [W-1:0] r, input int unsigned lat);
      int unsigned got_lat;
      bit ok;
      @(negedge clk);
      dividend = dvd;
      divisor  = dvs;
      start    = 1'b1;
      push_exp(q, r, lat);
      @(posedge clk);
      #1;
      start    = 1'b0;
      // Operands must no longer matter.
      dividend = W'($urandom);
      divisor  = W'($urandom);
      if (lat > 1) check({name, "_busy_done_low"}, {63'd0, done}, 64'd0);
      wait_done(0, got_lat, ok);
      compare_result(name, got_lat, ok);
   endtask

   initial begin
      int unsigned got_lat;
      bit ok;
      bit dropped;

      vecs[0] = '{dvd: 100, dvs: 7,  q: 14, r: 2,  lat: 15};
      vecs[1] = '{dvd: 5,   dvs: 9,  q: 0,  r: 5,  lat: 1};
      vecs[2] = '{dvd: 0,   dvs: 5,  q: 0,  r: 0,  lat: 1};
      vecs[3] = '{dvd: 7,   dvs: 7,  q: 1,  r: 0,  lat: 2};
      vecs[4] = '{dvd: 30,  dvs: 1,  q: 30, r: 0,  lat: 31};
      vecs[5] = '{dvd: 255, dvs: 16, q: 15, r: 15, lat: 16};
      vecs[6] = '{dvd: 6,   dvs: 7,  q: 0,  r: 6,  lat: 1};
      vecs[7] = '{dvd: 64,  dvs: 8,  q: 8,  r: 0,  lat: 9};

      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      #12;
      check("reset_done", {63'd0, done}, 64'd0);
      check("reset_quot", 64'(outputcount), 64'd0);
      check("reset_rem",  64'(remainder),   64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         run_op($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].lat);
      end

      for (int i = 0; i < 4; i++) begin
         logic [W-1:0] a;
         logic [W-1:0] b;
         a = W'($urandom_range(500, 0));
         b = W'($urandom_range(60, 1));
         run_op($sformatf("rand%0d", i), a, b, a / b, a % b, (a / b) + 1);
      end

      // Start held high: exactly one operation, done persists.
      @(negedge clk);
      dividend = 1024;
      divisor  = 1023;
      start    = 1'b1;
      push_exp(1, 1, 2);
      @(posedge clk);
      #1;
      wait_done(0, got_lat, ok);
      dropped = 1'b0;
      for (int unsigned n = got_lat; n < 100; n++) begin
         @(posedge clk);
         #1;
         if (!done || outputcount != 1 || remainder != 1) dropped = 1'b1;
      end
      check("held_no_rerun", {63'd0, dropped}, 64'd0);
      @(negedge clk);
      start = 1'b0;
      compare_result("held", got_lat, ok);

      // Asynchronous reset during BUSY aborts the operation.
      @(negedge clk);
      dividend = 100;
      divisor  = 7;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      check("abort_busy_quot", 64'(outputcount), 64'd5);
      rst_n = 1'b0;
      #1;
      check("abort_done", {63'd0, done}, 64'd0);
      check("abort_quot", 64'(outputcount), 64'd0);
      check("abort_rem",  64'(remainder),   64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("after_abort", 21, 7, 3, 0, 4);

      // Start edge during BUSY is ignored.
      @(negedge clk);
      dividend = 100;
      divisor  = 7;
      start    = 1'b1;
      push_exp(14, 2, 15);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      dividend = 9;
      divisor  = 3;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(4, got_lat, ok);
      compare_result("busy_restart", got_lat, ok);

      // Start already high as reset releases counts as an edge.
      @(negedge clk);
      rst_n    = 1'b0;
      start    = 1'b1;
      dividend = 50;
      divisor  = 5;
      @(negedge clk);
      rst_n = 1'b1;
      push_exp(10, 0, 11);
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(0, got_lat, ok);
      compare_result("start_at_reset", got_lat, ok);

      // Zero divisor.
`ifdef DBS_ZERO_DIVISOR_GUARD_EN
      run_op("zero_div", 42, 0, '1, 42, 1);
`else
      @(negedge clk);
      dividend = 42;
      divisor  = 0;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      dropped = 1'b0;
      for (int unsigned n = 0; n < 1000; n++) begin
         @(posedge clk);
         #1;
         if (done) dropped = 1'b1;
      end
      check("zero_div_never_done", {63'd0, dropped}, 64'd0);
      check("zero_div_rem", 64'(remainder), 64'd42);
      check("zero_div_quot", 64'(outputcount), 64'd1000);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_op("after_zero_div", 9, 3, 3, 0, 4);
`endif

      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/divide_by_subtraction.md
DIVIDE_BY_SUBTRACTION -- requirements
Module: divide_by_subtraction

Interface
REQ-001 The block SHALL take parameter WIDTH, default 512, as the operand, quotient and remainder bit width (the system MAX_DATA value).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a new division; rising-edge detected.
REQ-005 The block SHALL have port dividend, input, WIDTH bits: unsigned dividend, sampled at accept.
REQ-006 The block SHALL have port divisor, input, WIDTH bits: unsigned divisor, sampled at accept.
REQ-007 The block SHALL have port outputcount, output, WIDTH bits: quotient, i.e. the number of subtractions performed.
REQ-008 The block SHALL have port remainder, output, WIDTH bits: remainder.
REQ-009 The block SHALL have port done, output, 1 bit: result valid; a level held until the next accept.

Function
REQ-010 The block SHALL implement states IDLE, BUSY and DONE.
REQ-011 The block SHALL register start every cycle as start_q, and SHALL define a start edge as start=1 while start_q=0.
REQ-012 On a start edge in IDLE or DONE, the block SHALL accept at that edge:
- remainder <= dividend
- outputcount <= 0
- latch divisor internally
- done <= 0
- state <= BUSY
REQ-013 The block SHALL ignore start edges that occur in BUSY, so that operands and progress are unaffected.
REQ-014 In BUSY, at each edge where remainder >= latched divisor, the block SHALL apply remainder <= remainder - divisor and outputcount <= outputcount + 1.
REQ-015 In BUSY, at the edge where remainder < latched divisor, the block SHALL apply done <= 1 and state <= DONE, leaving the outputs unchanged.
REQ-016 Latency: for quotient Q, done SHALL rise at the (Q+1)th rising edge after the accept edge.
REQ-017 All comparisons and arithmetic SHALL be unsigned and WIDTH bits; the quotient never exceeds the dividend, so no overflow handling is required.
REQ-018 outputcount and remainder SHALL show running values during BUSY, are valid only while done=1, and SHALL hold constant in DONE.
REQ-019 Holding start high continuously SHALL cause exactly one operation; the result and done SHALL persist until start falls and rises again.
REQ-020 Input changes after accept SHALL have no effect on the running operation.

Reset
REQ-021 While rst_n=0, the block SHALL force state=IDLE, done=0, outputcount=0, remainder=0, latched divisor=0 and start_q=0, immediately and independent of clk.
REQ-022 Reset asserted mid-BUSY SHALL abort the operation, with no completion signalled.
REQ-023 If start is already high when rst_n deasserts, that SHALL count as a start edge at the first clock edge, because start_q=0.

Configuration
REQ-024 With macro DBS_ZERO_DIVISOR_GUARD_EN defined, an operation accepted with divisor=0 SHALL complete at the first BUSY edge with done=1, outputcount=all ones and remainder=dividend.
REQ-025 Without DBS_ZERO_DIVISOR_GUARD_EN, the block SHALL apply no special handling: divisor=0 keeps the block in BUSY indefinitely (count increments, remainder unchanged) until reset.

Verification
REQ-026 Apply dividend=100, divisor=7 with a start pulse -> done rises 15 edges after accept with outputcount=14 and remainder=2.
REQ-027 Apply dividend=5, divisor=9 -> done after 1 edge with outputcount=0 and remainder=5.
REQ-028 Apply dividend=1024, divisor=1023 with start held high for 100 cycles -> one result (1, 1), and done stays high throughout.
REQ-029 Pulse rst_n low during BUSY of 100/7 -> done=0 and outputs=0 immediately; a new start of 21/7 -> (3, 0) after 4 edges.
REQ-030 Give a start edge during BUSY of 100/7 with inputs 9/3 -> ignored; the result is still (14, 2).
REQ-031 Apply dividend=42, divisor=0 with the guard macro defined -> done after 1 edge with outputcount=all ones and remainder=42; without the macro, done stays 0 for 1000 cycles.
